// File: rtl/icache_pkg.sv
// Shared geometry, field positions and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned NUM_BLOCKS      = 8;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned ADDR_BITS       = 10;
    localparam int unsigned DEF_CNT_W       = 16;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned BLOCK_W = WORDS_PER_BLOCK * WORD_W;
    localparam int unsigned REQ_W   = TAG_W + IDX_W;

    // Bit positions of the PC fields: tag = PC[9:7], index = PC[6:4], offset = PC[3:2]
    localparam int unsigned OFF_LSB = 2;
    localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
    localparam int unsigned TAG_LSB = ADDR_BITS - TAG_W;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t READ   = 2'd1;
    localparam state_t UPDATE = 2'd2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } req_addr_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: one write port, combinational indexed read.
module icache_line_array
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_d [NUM_BLOCKS];

    // Reset only invalidates lines; tag and data contents are left as they are
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
        if (RESET) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: zero-latency hit path, block refill FSM and
// saturating hit/miss performance counters.
module icache_controller
    import icache_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic [REQ_W-1:0]     MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]   MEM_READDATA,
    input  logic                 MEM_BUSYWAIT,
    output logic [CNT_WIDTH-1:0] HIT_COUNT,
    output logic [CNT_WIDTH-1:0] MISS_COUNT
);

    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_off;
    logic             pc_unused_c;

    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] line_words;
    logic               hit_c;

    state_t                state_q, state_d;
    state_t                prev_state_q, prev_state_d;
    req_addr_t             req_addr_q, req_addr_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
    logic                  busywait_c;
    logic                  mem_read_c;
    logic                  fill_en_c;

    assign pc_tag      = PC[TAG_LSB +: TAG_W];
    assign pc_idx      = PC[IDX_LSB +: IDX_W];
    assign pc_off      = PC[OFF_LSB +: OFF_W];
    assign pc_unused_c = ^{PC[31:ADDR_BITS], PC[OFF_LSB-1:0]};

    icache_line_array u_lines (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_en    (fill_en_c),
        .wr_idx   (req_addr_q.idx),
        .wr_tag   (req_addr_q.tag),
        .wr_data  (MEM_READDATA),
        .rd_idx   (pc_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign hit_c       = line_valid && (line_tag == pc_tag);
    assign line_words  = line_data;
    assign INSTRUCTION = line_words[pc_off];

    // The first READ cycle is recognised by the previous state still being IDLE;
    // a hit right after UPDATE is the tail of a miss and is not counted again.
    always_comb begin
        state_d      = state_q;
        prev_state_d = state_q;
        req_addr_d   = req_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        busywait_c   = 1'b0;
        mem_read_c   = 1'b0;
        fill_en_c    = 1'b0;
        case (state_q)
            IDLE: begin
                busywait_c = !hit_c;
                if (!hit_c) begin
                    req_addr_d.tag = pc_tag;
                    req_addr_d.idx = pc_idx;
                    state_d        = READ;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                end else if (prev_state_q != UPDATE) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                end
            end
            READ: begin
                busywait_c = 1'b1;
                mem_read_c = 1'b1;
                if (prev_state_q == READ && !MEM_BUSYWAIT) begin
                    fill_en_c = 1'b1;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                busywait_c = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (RESET) begin
            state_d      = IDLE;
            prev_state_d = IDLE;
            hit_cnt_d    = '0;
            miss_cnt_d   = '0;
            busywait_c   = 1'b0;
            mem_read_c   = 1'b0;
            fill_en_c    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q      <= state_d;
        prev_state_q <= prev_state_d;
        req_addr_q   <= req_addr_d;
        hit_cnt_q    <= hit_cnt_d;
        miss_cnt_q   <= miss_cnt_d;
    end

    assign BUSYWAIT    = busywait_c;
    assign MEM_READ    = mem_read_c;
    assign MEM_ADDRESS = req_addr_q;
    assign HIT_COUNT   = hit_cnt_q;
    assign MISS_COUNT  = miss_cnt_q;

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache between the program-counter stage and the 1024-byte instruction memory.
- Takes the current 32-bit PC and returns the 32-bit INSTRUCTION for that address.
- Raises BUSYWAIT on a miss; the PC stage uses it as its HOLD input and freezes.
- Refills one 16-byte block from instruction memory through a request/busywait handshake.

Parameters:
- NUM_BLOCKS, 8: cache lines. Index width = log2(NUM_BLOCKS) = 3.
- WORDS_PER_BLOCK, 4: 32-bit words per line. Block = 128 bits, offset = PC[3:2].
- ADDR_BITS, 10: PC bits used; PC[31:10] ignored.
- CNT_WIDTH, 16: width of the hit/miss performance counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- PC  in  32  instruction byte address, word aligned; tag = PC[9:7], index = PC[6:4], word offset = PC[3:2].
- INSTRUCTION  out  32  selected word of the indexed line.
- BUSYWAIT  out  1  high while the requested instruction is not available; drives the PC stage's HOLD.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address {tag,index} of the refill.
- MEM_READDATA  in  128  refill block; word0 = bits[31:0] … word3 = bits[127:96].
- MEM_BUSYWAIT  in  1  memory busy; low with valid MEM_READDATA signals completion.
- HIT_COUNT  out  CNT_WIDTH  saturating hit counter.
- MISS_COUNT  out  CNT_WIDTH  saturating miss counter.

Behaviour:
Reset (RESET high at posedge):
- Clear all valid bits, state := IDLE, both counters := 0.
- MEM_READ = 0 and BUSYWAIT = 0 while in reset.
- Tags and data are not cleared.

Hit detection (combinational, same cycle as PC):
- hit = valid[index] && tag_array[index] == PC[9:7].
- INSTRUCTION = data[index] word PC[3:2], output regardless of hit.
- Hit latency is 0 cycles: a word presented in IDLE is usable the same cycle.

FSM, three states:
- IDLE:
  - BUSYWAIT = !hit.
  - On a miss, latch {tag,index} into req_addr, MISS_COUNT++, next state READ.
  - On a hit with the previous state not UPDATE, HIT_COUNT++.
- READ:
  - BUSYWAIT = 1, MEM_READ = 1, MEM_ADDRESS = req_addr.
  - MEM_BUSYWAIT is ignored in the first READ cycle (memory registers the request).
  - In any later READ cycle with MEM_BUSYWAIT = 0: capture MEM_READDATA into line req_addr[2:0], tag := req_addr[5:3], valid := 1, next state UPDATE.
- UPDATE:
  - BUSYWAIT = 1, MEM_READ = 0; next state IDLE.
  - In IDLE the line now hits and BUSYWAIT falls.

Miss penalty:
- 1 (detect) + memory cycles + 1 (UPDATE).
- Worked case, memory busy 4 cycles: miss seen at cycle T, BUSYWAIT low from T+6.

Boundary conditions:
- The refill always uses latched req_addr. A PC change during READ/UPDATE must not alter the request. It cannot happen in normal operation because HOLD freezes PC.
- RESET during READ or UPDATE: abort immediately, MEM_READ drops the next cycle, no line is written, state := IDLE with all lines invalid.
- A miss on a valid line with a different tag overwrites it; no write-back (read-only cache).
- Both counters saturate at all-ones; no wrap-around.
- A hit in the IDLE cycle right after UPDATE is not counted as a hit (already counted as a miss).
- PC[1:0] ≠ 0: ignored, treated as word aligned.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, READ, UPDATE}
  - TAG_W = 3, IDX_W = 3, OFF_W = 2, BLOCK_W = 128
  - field-extraction constants for tag/index/offset positions.
- One natural sub-module, icache_line_array:
  - valid/tag/data storage, clear-on-reset of valid bits, single write port, combinational read of the indexed line.
- The FSM, counters and hit logic live in icache_controller.

Test Plan:
- Cold miss:
  - Stimulus: reset, PC = 0x000; memory model 4-cycle busy returning block 0x44443333_22221111_AAAA0000_DEADBEEF.
  - Required: BUSYWAIT high 6 cycles, MEM_ADDRESS = 0, then INSTRUCTION = 0xDEADBEEF with BUSYWAIT low. MISS_COUNT = 1, HIT_COUNT = 0.
- Spatial hits:
  - Stimulus: after the cold miss, PC = 0x004, 0x008, 0x00C on consecutive cycles.
  - Required: BUSYWAIT stays 0, INSTRUCTION = 0xAAAA0000, 0x22221111, 0x44443333. HIT_COUNT = 3.
- Conflict miss:
  - Stimulus: PC = 0x080 (tag 1, index 0) after line 0 is filled with tag 0.
  - Required: miss, MEM_ADDRESS = 6'b001000, line 0 replaced.
  - Then PC = 0x000: required miss again, MISS_COUNT = 3.
- Reset mid-refill:
  - Stimulus: miss on PC = 0x010, assert RESET in the 2nd READ cycle.
  - Required: next cycle MEM_READ = 0, BUSYWAIT = 0, counters = 0. The following PC = 0x010 access misses (line not written).
- Request stability:
  - Stimulus: miss on PC = 0x020, force PC = 0x3F0 during READ.
  - Required: MEM_ADDRESS stays 6'b000010 and line 2 is filled with tag 0.
- Counter saturation:
  - Stimulus: CNT_WIDTH = 4, 20 consecutive hit cycles.
  - Required: HIT_COUNT holds 4'hF.
